// File: rtl/fb_cmd_ctrl.sv
// fb_cmd_ctrl: parses UART command packets into back-buffer row writes, fills and clears,
// and swaps the displayed buffer only at a frame boundary. Define FB_CMD_CHECKSUM_EN for trailing XOR checksums.
module fb_cmd_ctrl #(
  parameter int         FB_DEPTH       = 8,
  parameter int         WORD_BYTES     = 4,
  parameter int         TIMEOUT_CYCLES = 1000,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        rx_dv,
  input  logic [7:0]                  rx_byte,
  input  logic                        frame_start,
  output logic                        fb_we,
  output logic [$clog2(FB_DEPTH)-1:0] fb_waddr,
  output logic [8*WORD_BYTES-1:0]     fb_wdata,
  output logic                        fb_wbuf,
  output logic                        disp_buf,
  output logic                        busy,
  output logic                        err,
  output logic                        swap_done
);

  localparam int FB_WIDTH = 8 * WORD_BYTES;
  localparam int AW       = $clog2(FB_DEPTH);
  localparam int CW       = $clog2(WORD_BYTES) + 1;
  localparam int TW       = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_DATA   = 3'd2,
    ST_COMMIT = 3'd3,
    ST_FILL   = 3'd4
`ifdef FB_CMD_CHECKSUM_EN
    , ST_CSUM = 3'd5
`endif
  } state_e;

  state_e                state_q, state_d;
  logic [AW-1:0]         row_q, row_d;
  logic                  op_fill_q, op_fill_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [FB_WIDTH-1:0]   shadow_q, shadow_d;
  logic [7:0]            csum_q, csum_d;
  logic [TW-1:0]         tmo_q, tmo_d;
  logic                  swap_pending_q, swap_pending_d;
  logic                  disp_buf_q, disp_buf_d;
  logic                  fb_we_q, fb_we_d;
  logic [AW-1:0]         fb_waddr_q, fb_waddr_d;
  logic [FB_WIDTH-1:0]   fb_wdata_q, fb_wdata_d;
  logic                  err_q, err_d;
  logic                  swap_done_q, swap_done_d;

  logic dv_s;
  logic counting_s;
  logic timed_out_s;
  logic last_byte_s;
  logic go_s;

  // Next-state, datapath and output decode
  always_comb begin
    state_d        = state_q;
    row_d          = row_q;
    op_fill_d      = op_fill_q;
    cnt_d          = cnt_q;
    shadow_d       = shadow_q;
    csum_d         = csum_q;
    swap_pending_d = swap_pending_q;
    disp_buf_d     = disp_buf_q;
    fb_we_d        = 1'b0;
    fb_waddr_d     = fb_waddr_q;
    fb_wdata_d     = fb_wdata_q;
    err_d          = 1'b0;
    swap_done_d    = 1'b0;
    go_s           = 1'b0;

    // Bytes arriving while a swap waits for its frame boundary are refused.
    dv_s = rx_dv & ~swap_pending_q;
    if (rx_dv && swap_pending_q) begin
      err_d = 1'b1;
    end else begin
      err_d = 1'b0;
    end

`ifdef FB_CMD_CHECKSUM_EN
    counting_s = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_CSUM);
`else
    counting_s = (state_q == ST_HDR) || (state_q == ST_DATA);
`endif
    if (rx_dv || !counting_s) begin
      tmo_d = '0;
    end else begin
      tmo_d = tmo_q + TW'(1);
    end
    timed_out_s = counting_s && !rx_dv && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

    if (op_fill_q) begin
      last_byte_s = (cnt_q == CW'(0));
    end else begin
      last_byte_s = (cnt_q == CW'(WORD_BYTES - 1));
    end

    if (swap_pending_q && frame_start) begin
      disp_buf_d     = ~disp_buf_q;
      swap_done_d    = 1'b1;
      swap_pending_d = 1'b0;
    end else begin
      swap_done_d    = 1'b0;
    end

    if (timed_out_s) begin
      err_d   = 1'b1;
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (dv_s && (rx_byte == SYNC_BYTE)) begin
            state_d = ST_HDR;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_HDR: begin
          if (dv_s) begin
            csum_d = rx_byte;
            cnt_d  = '0;
            case (rx_byte[7:5])
              3'd0: begin
                if (int'(rx_byte[3:0]) >= FB_DEPTH) begin
                  err_d   = 1'b1;
                  state_d = ST_IDLE;
                end else begin
                  row_d     = AW'(rx_byte[3:0]);
                  op_fill_d = 1'b0;
                  state_d   = ST_DATA;
                end
              end
              3'd1: begin
                op_fill_d = 1'b1;
                state_d   = ST_DATA;
              end
              3'd2: begin
                swap_pending_d = 1'b1;
                state_d        = ST_IDLE;
              end
              3'd3: begin
                state_d    = ST_FILL;
                fb_we_d    = 1'b1;
                fb_waddr_d = '0;
                fb_wdata_d = '0;
              end
              default: begin
                err_d   = 1'b1;
                state_d = ST_IDLE;
              end
            endcase
          end else begin
            state_d = ST_HDR;
          end
        end
        ST_DATA: begin
          if (dv_s) begin
            shadow_d = {shadow_q[FB_WIDTH-9:0], rx_byte};
            csum_d   = csum_q ^ rx_byte;
            cnt_d    = cnt_q + CW'(1);
            if (last_byte_s) begin
`ifdef FB_CMD_CHECKSUM_EN
              state_d = ST_CSUM;
`else
              go_s    = 1'b1;
`endif
            end else begin
              state_d = ST_DATA;
            end
          end else begin
            state_d = ST_DATA;
          end
        end
`ifdef FB_CMD_CHECKSUM_EN
        ST_CSUM: begin
          if (dv_s) begin
            if (rx_byte == csum_q) begin
              go_s = 1'b1;
            end else begin
              err_d   = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            state_d = ST_CSUM;
          end
        end
`endif
        ST_COMMIT: begin
          err_d   = err_d | rx_dv;
          state_d = ST_IDLE;
        end
        ST_FILL: begin
          err_d = err_d | rx_dv;
          if (fb_waddr_q == AW'(FB_DEPTH - 1)) begin
            state_d = ST_IDLE;
          end else begin
            fb_we_d    = 1'b1;
            fb_waddr_d = fb_waddr_q + AW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    // Launch the row commit or the whole-buffer fill the cycle after the final accepted byte.
    if (go_s) begin
      fb_we_d = 1'b1;
      if (op_fill_q) begin
        state_d    = ST_FILL;
        fb_waddr_d = '0;
        fb_wdata_d = {WORD_BYTES{shadow_d[7:0]}};
      end else begin
        state_d    = ST_COMMIT;
        fb_waddr_d = row_q;
        fb_wdata_d = shadow_d;
      end
    end else begin
      fb_wdata_d = fb_wdata_d;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      row_q          <= '0;
      op_fill_q      <= 1'b0;
      cnt_q          <= '0;
      shadow_q       <= '0;
      csum_q         <= 8'h00;
      tmo_q          <= '0;
      swap_pending_q <= 1'b0;
      disp_buf_q     <= 1'b0;
      fb_we_q        <= 1'b0;
      fb_waddr_q     <= '0;
      fb_wdata_q     <= '0;
      err_q          <= 1'b0;
      swap_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      row_q          <= row_d;
      op_fill_q      <= op_fill_d;
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      csum_q         <= csum_d;
      tmo_q          <= tmo_d;
      swap_pending_q <= swap_pending_d;
      disp_buf_q     <= disp_buf_d;
      fb_we_q        <= fb_we_d;
      fb_waddr_q     <= fb_waddr_d;
      fb_wdata_q     <= fb_wdata_d;
      err_q          <= err_d;
      swap_done_q    <= swap_done_d;
    end
  end

  assign fb_we     = fb_we_q;
  assign fb_waddr  = fb_waddr_q;
  assign fb_wdata  = fb_wdata_q;
  assign disp_buf  = disp_buf_q;
  assign fb_wbuf   = ~disp_buf_q;
  assign busy      = (state_q != ST_IDLE) || swap_pending_q;
  assign err       = err_q;
  assign swap_done = swap_done_q;

endmodule

// File: doc/fb_cmd_ctrl.md
Name: fb_cmd_ctrl

Overview:
- Command sequencer that owns the frame-buffer write port of the LED panel pipeline.
- Parses a byte stream from the UART receiver into row writes, fills and clears, and writes the back buffer of a double-buffered frame store.
- Swaps the display buffer only at a panel frame boundary, so the scan path never shows a half-written frame.

Parameters:
FB_DEPTH, 8, number of frame-buffer rows.
WORD_BYTES, 4, bytes per row word; FB_WIDTH = 8*WORD_BYTES.
TIMEOUT_CYCLES, 1000, maximum idle clocks between bytes inside a packet.
SYNC_BYTE, 8'hA5, packet start marker.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
rx_dv  in  1  one-cycle strobe: rx_byte valid
rx_byte  in  8  received UART byte
frame_start  in  1  one-cycle pulse from panel scanner at start of frame
fb_we  out  1  frame-buffer write enable
fb_waddr  out  $clog2(FB_DEPTH)  write row address
fb_wdata  out  FB_WIDTH  write data
fb_wbuf  out  1  buffer being written; always ~disp_buf
disp_buf  out  1  buffer selected for display
busy  out  1  high in any state other than IDLE, or while a swap is pending
err  out  1  one-cycle error pulse
swap_done  out  1  one-cycle pulse when disp_buf toggles

Behaviour:
- Reset values (async assert, sync release): all outputs 0; state IDLE; swap_pending 0; timeout counter 0.
- Packet format: SYNC_BYTE, then header, then payload.
  - Header [7:5] is the opcode; header [3:0] is the row.
  - Op 0 WRITE: WORD_BYTES data bytes, MSB first.
  - Op 1 FILL: one byte, replicated into every byte lane of every row.
  - Op 2 SWAP: no payload.
  - Op 3 CLEAR: no payload; writes 0 to all rows.
  - Ops 4-7: err pulse, return to IDLE.
- States: IDLE, HDR, DATA, (CSUM), COMMIT, FILL.
- IDLE: rx_dv with SYNC_BYTE -> HDR; any other byte is ignored silently.
- HDR: rx_dv decodes the header.
  - WRITE with row >= FB_DEPTH: err, -> IDLE.
  - WRITE: latch row, clear byte counter, -> DATA.
  - FILL: -> DATA, expecting 1 byte.
  - CLEAR: -> FILL with fill value 0.
  - SWAP: set swap_pending, -> IDLE.
- DATA: each rx_dv shifts the byte into the shadow word. After the last byte -> COMMIT (WRITE) or FILL (FILL op).
- COMMIT: fb_we=1 for exactly one cycle, the cycle after the last byte's rx_dv; fb_waddr=row, fb_wdata=shadow word; then -> IDLE.
- FILL: fb_we=1 for FB_DEPTH consecutive cycles, addresses 0..FB_DEPTH-1 ascending, starting the cycle after the triggering rx_dv; then -> IDLE.
- Dropped bytes: any rx_dv during COMMIT or FILL is dropped with an err pulse. Any rx_dv while swap_pending=1 is dropped with an err pulse.
- Timeout: the counter clears on every rx_dv and counts in HDR/DATA/CSUM. When it reaches TIMEOUT_CYCLES: err pulse, -> IDLE, shadow word discarded, no write.
- Swap:
  - While swap_pending, the first frame_start strictly after the cycle in which it was set toggles disp_buf; swap_done pulses that same cycle and swap_pending clears.
  - A frame_start in the same cycle as the SWAP header does not swap.
  - fb_wbuf follows disp_buf combinationally as its inverse.
- Simultaneous events: a timeout and an rx_dv in the same cycle -> rx_dv wins; the byte is accepted.
- Reset mid-operation: any in-flight write or fill is abandoned, fb_we drops immediately, disp_buf returns to 0.

Optional Feature:
- Macro FB_CMD_CHECKSUM_EN.
- Defined:
  - WRITE and FILL packets carry one trailing byte, the XOR of the header and all payload bytes.
  - DATA -> CSUM; on rx_dv in CSUM, a match -> COMMIT/FILL.
  - A mismatch -> err pulse, IDLE, no write.
  - Timeout applies in CSUM.
- Undefined: no CSUM state; behaviour exactly as above.

Test Plan:
- A5, 00, 11, 22, 33, 44 -> one fb_we, the cycle after the 0x44 strobe; fb_waddr=0, fb_wdata=0x11223344, fb_wbuf=1.
- A5, 25, 0F (FILL; the row field is ignored) -> fb_we high 8 consecutive cycles, addr 0..7, data 0x0F0F0F0F each; a byte injected mid-fill -> err pulse, byte dropped.
- A5, 40 (SWAP), frame_start 50 cycles later -> disp_buf 0->1 with swap_done on that cycle; a byte sent before frame_start -> err, dropped; frame_start in the header cycle -> no swap.
- A5, 07, 11 then TIMEOUT_CYCLES idle clocks -> err pulse, no fb_we, state IDLE; next A5 packet works normally.
- A5, 09 (row 9 >= FB_DEPTH) and A5, E0 (op 7) -> err pulse each, no write; reset asserted mid-FILL -> fb_we=0 immediately, disp_buf=0.
- With FB_CMD_CHECKSUM_EN: A5, 00, 01, 02, 03, 04, 04 -> write 0x01020304; same packet with checksum 05 -> err, no write.
